// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage sequencer for the LC-3b pipeline. Issues one data
//               memory transaction for LDR/STR/LDB/STB/TRAP and two for
//               LDI/STI (pointer fetch, then the real access). Handles byte
//               lanes, LDB sign extension and indirection, and holds the
//               pipeline via stall until the result is registered.
// Ports       : clk, rst            - clock, async active-high reset
//               valid_in, opcode    - MEM-stage instruction and its validity
//               addr, store_data    - effective address and SR value
//               mem_resp, mem_rdata - data-memory completion and read data
//               mem_read/mem_write/mem_address/mem_wdata/mem_byte_enable
//                                   - data-memory request
//               load_data           - registered load/TRAP result
//               stall, done         - pipeline hold, one-cycle completion
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] addr,
   input  logic [WIDTH-1:0] store_data,
   input  logic             mem_resp,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic             mem_read,
   output logic             mem_write,
   output logic [WIDTH-1:0] mem_address,
   output logic [WIDTH-1:0] mem_wdata,
   output logic [1:0]       mem_byte_enable,
   output logic [WIDTH-1:0] load_data,
   output logic             stall,
   output logic             done
);

   localparam logic [3:0] OP_LDB  = 4'b0010;
   localparam logic [3:0] OP_STB  = 4'b0011;
   localparam logic [3:0] OP_LDR  = 4'b0110;
   localparam logic [3:0] OP_STR  = 4'b0111;
   localparam logic [3:0] OP_LDI  = 4'b1010;
   localparam logic [3:0] OP_STI  = 4'b1011;
   localparam logic [3:0] OP_TRAP = 4'b1111;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ1 = 2'd1;
   localparam logic [1:0] S_REQ2 = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       r_state;
   logic [1:0]       w_next_state;
   logic [3:0]       r_op;
   logic [WIDTH-1:0] r_addr;
   logic [WIDTH-1:0] r_sdata;
   logic [WIDTH-1:0] r_ptr;
   logic [WIDTH-1:0] r_load_data;

   logic             w_is_mem_op;
   logic             w_start;
   logic             w_indirect;
   logic [WIDTH-1:0] w_addr_word;
   logic [7:0]       w_rbyte;
   logic [WIDTH-1:0] w_byte_sext;

   always_comb begin
      w_is_mem_op = 1'b0;
      case (opcode)
         OP_LDR, OP_STR, OP_LDB, OP_STB,
         OP_LDI, OP_STI, OP_TRAP: w_is_mem_op = 1'b1;
         default:                 w_is_mem_op = 1'b0;
      endcase
   end

   assign w_start     = valid_in & w_is_mem_op;
   assign w_indirect  = (r_op == OP_LDI) || (r_op == OP_STI);
   assign w_addr_word = {r_addr[WIDTH-1:1], 1'b0};
   // Odd byte address selects the high lane of the returned word.
   assign w_rbyte     = r_addr[0] ? mem_rdata[15:8] : mem_rdata[7:0];
   assign w_byte_sext = {{(WIDTH-8){w_rbyte[7]}}, w_rbyte};
   assign load_data   = r_load_data;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: if (w_start) w_next_state = S_REQ1;
         S_REQ1: if (mem_resp) w_next_state = w_indirect ? S_REQ2 : S_DONE;
         S_REQ2: if (mem_resp) w_next_state = S_DONE;
         // DONE never looks at valid_in: the instruction still presented
         // there is the one that just completed.
         S_DONE: w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------- datapath
   // Captured copies keep the request stable while upstream inputs wander.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op        <= '0;
         r_addr      <= '0;
         r_sdata     <= '0;
         r_ptr       <= '0;
         r_load_data <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_op    <= opcode;
                  r_addr  <= addr;
                  r_sdata <= store_data;
               end
            end
            S_REQ1: begin
               if (mem_resp) begin
                  case (r_op)
                     OP_LDI, OP_STI:  r_ptr       <= {mem_rdata[WIDTH-1:1], 1'b0};
                     OP_LDR, OP_TRAP: r_load_data <= mem_rdata;
                     OP_LDB:          r_load_data <= w_byte_sext;
                     default:         ;
                  endcase
               end
            end
            S_REQ2: begin
               if (mem_resp && (r_op == OP_LDI)) begin
                  r_load_data <= mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   // -------------------------------------------------------------- outputs
   // Requests are decoded purely from state and captured registers, so they
   // stay stable until mem_resp and drop on the following edge.
   always_comb begin
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_address     = '0;
      mem_wdata       = '0;
      mem_byte_enable = 2'b00;
      stall           = 1'b0;
      done            = 1'b0;
      case (r_state)
         S_IDLE: begin
            stall = w_start;
         end
         S_REQ1: begin
            stall = 1'b1;
            case (r_op)
               OP_LDR, OP_LDI, OP_TRAP, OP_STI: begin
                  mem_read    = 1'b1;
                  mem_address = w_addr_word;
               end
               OP_LDB: begin
                  mem_read    = 1'b1;
                  mem_address = r_addr;
               end
               OP_STR: begin
                  mem_write       = 1'b1;
                  mem_address     = w_addr_word;
                  mem_wdata       = r_sdata;
                  mem_byte_enable = 2'b11;
               end
               OP_STB: begin
                  mem_write       = 1'b1;
                  mem_address     = r_addr;
                  mem_wdata       = {r_sdata[7:0], r_sdata[7:0]};
                  mem_byte_enable = r_addr[0] ? 2'b10 : 2'b01;
               end
               default: ;
            endcase
         end
         S_REQ2: begin
            stall       = 1'b1;
            mem_address = r_ptr;
            if (r_op == OP_STI) begin
               mem_write       = 1'b1;
               mem_wdata       = r_sdata;
               mem_byte_enable = 2'b11;
            end else begin
               mem_read = 1'b1;
            end
         end
         S_DONE: begin
            done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit. Table of
//               instructions with expected requests, stall counts and
//               results; load results go through a scoreboard queue popped on
//               done. Hand-written sequences cover non-memory ops and a reset
//               during the second access followed by a stray response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_LDB  = 4'b0010;
   localparam logic [3:0] OP_STB  = 4'b0011;
   localparam logic [3:0] OP_LDR  = 4'b0110;
   localparam logic [3:0] OP_STR  = 4'b0111;
   localparam logic [3:0] OP_LDI  = 4'b1010;
   localparam logic [3:0] OP_STI  = 4'b1011;
   localparam logic [3:0] OP_TRAP = 4'b1111;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_in = 1'b0;
   logic [3:0]  opcode = 4'h0;
   logic [15:0] addr = 16'h0;
   logic [15:0] store_data = 16'h0;
   logic        mem_resp;
   logic [15:0] mem_rdata;
   logic        mem_read, mem_write;
   logic [15:0] mem_address, mem_wdata, load_data;
   logic [1:0]  mem_byte_enable;
   logic        stall, done;

   logic        tb_resp  = 1'b0;
   logic        tb_stray = 1'b0;
   logic [15:0] tb_rdata = 16'h0;
   assign mem_resp  = tb_resp | tb_stray;
   assign mem_rdata = tb_stray ? 16'h9999 : tb_rdata;

   int tests = 0;
   int fails = 0;
   int lat = 1;
   int wait_cnt = 0;
   logic [15:0] mem [int];
   logic [15:0] sb [$];

   always #5 clk = ~clk;

   mem_access_unit #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .opcode(opcode),
      .addr(addr), .store_data(store_data), .mem_resp(mem_resp),
      .mem_rdata(mem_rdata), .mem_read(mem_read), .mem_write(mem_write),
      .mem_address(mem_address), .mem_wdata(mem_wdata),
      .mem_byte_enable(mem_byte_enable), .load_data(load_data),
      .stall(stall), .done(done)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] rd(input logic [15:0] a);
      int k;
      k = int'({a[15:1], 1'b0});
      return mem.exists(k) ? mem[k] : 16'h0000;
   endfunction

   // Memory model: responds on the lat-th cycle a request is visible.
   always @(posedge clk) begin : b_resp
      int k;
      logic [15:0] cur;
      #1;
      if (tb_resp) begin
         tb_resp  = 1'b0;
         wait_cnt = 0;
      end
      if (mem_read || mem_write) begin
         if (wait_cnt >= lat - 1) begin
            tb_resp  = 1'b1;
            tb_rdata = rd(mem_address);
            if (mem_write) begin
               k   = int'({mem_address[15:1], 1'b0});
               cur = rd(mem_address);
               if (mem_byte_enable[1]) cur[15:8] = mem_wdata[15:8];
               if (mem_byte_enable[0]) cur[7:0]  = mem_wdata[7:0];
               mem[k] = cur;
            end
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
      end
   end

   // Protocol invariants and scoreboard pop on done.
   always @(negedge clk) begin
      #1;
      if (!rst) begin
         chk("rw_exclusive", 64'(mem_read & mem_write), 64'(0));
         if (!mem_write) chk("be_zero_no_write", 64'(mem_byte_enable), 64'(0));
         if (done) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL sb_unexpected_done: got done expected none");
            end else begin
               chk("sb_load_data", 64'(load_data), 64'(sb.pop_front()));
            end
         end
      end
   end

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a, sd;
      int          lt;
      bit          scr;
      int          nreq;
      bit          w1;
      logic [15:0] a1, d1;
      logic [1:0]  be1;
      bit          w2;
      logic [15:0] a2, d2;
      logic [1:0]  be2;
      int          stalls;
      logic [15:0] ld;
   } vec_t;

   function automatic vec_t mk(input logic [3:0] op, input logic [15:0] a, sd,
                               input int lt, input bit scr, input int nreq,
                               input bit w1, input logic [15:0] a1, d1, input logic [1:0] be1,
                               input bit w2, input logic [15:0] a2, d2, input logic [1:0] be2,
                               input int stalls, input logic [15:0] ld);
      vec_t v;
      v.op = op; v.a = a; v.sd = sd; v.lt = lt; v.scr = scr; v.nreq = nreq;
      v.w1 = w1; v.a1 = a1; v.d1 = d1; v.be1 = be1;
      v.w2 = w2; v.a2 = a2; v.d2 = d2; v.be2 = be2;
      v.stalls = stalls; v.ld = ld;
      return v;
   endfunction

   task automatic run(input vec_t v, input int idx);
      logic [15:0] ra [2];
      logic [15:0] rdd [2];
      logic [1:0]  rbe [2];
      bit          rw [2];
      logic [35:0] prev_sig, cur_sig;
      int nreq = 0, stalls = 0, cyc = 0;
      bit prev_req = 0, prev_resp = 0, fin = 0;
      string t;
      t = $sformatf("v%0d", idx);
      @(negedge clk);
      valid_in = 1'b1; opcode = v.op; addr = v.a; store_data = v.sd; lat = v.lt;
      sb.push_back(v.ld);
      prev_sig = '0;
      while (!fin && cyc < 64) begin
         #1;
         cyc++;
         if (stall) stalls++;
         cur_sig = {mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata};
         if (mem_read || mem_write) begin
            if (!prev_req || prev_resp) begin
               if (nreq < 2) begin
                  rw[nreq] = mem_write; ra[nreq] = mem_address;
                  rdd[nreq] = mem_wdata; rbe[nreq] = mem_byte_enable;
               end
               nreq++;
            end else begin
               chk({t, "_req_stable"}, 64'(cur_sig), 64'(prev_sig));
            end
         end else if (prev_req && !prev_resp) begin
            tests++;
            fails++;
            $display("FAIL %s_req_dropped: got no request expected request held", t);
         end
         prev_sig  = cur_sig;
         prev_req  = mem_read || mem_write;
         prev_resp = mem_resp;
         if (done) begin
            fin = 1;
         end else begin
            if (v.scr && cyc == 2) begin
               addr = 16'hFFFF; opcode = OP_STR; store_data = 16'h0BAD;
            end
            @(negedge clk);
         end
      end
      if (!fin) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: got no done expected done within 64 cycles", t);
         sb.delete();
      end
      chk({t, "_stall_cycles"}, 64'(stalls), 64'(v.stalls));
      chk({t, "_done_cycle"}, 64'(cyc), 64'(v.stalls + 1));
      chk({t, "_num_req"}, 64'(nreq), 64'(v.nreq));
      if (nreq >= 1) begin
         chk({t, "_req1_write"}, 64'(rw[0]), 64'(v.w1));
         chk({t, "_req1_addr"}, 64'(ra[0]), 64'(v.a1));
         if (v.w1) chk({t, "_req1_wdata_be"}, 64'({rdd[0], rbe[0]}), 64'({v.d1, v.be1}));
      end
      if (nreq >= 2 && v.nreq == 2) begin
         chk({t, "_req2_write"}, 64'(rw[1]), 64'(v.w2));
         chk({t, "_req2_addr"}, 64'(ra[1]), 64'(v.a2));
         if (v.w2) chk({t, "_req2_wdata_be"}, 64'({rdd[1], rbe[1]}), 64'({v.d2, v.be2}));
      end
      // Cycle after done: back in IDLE, no request and no second done pulse.
      @(negedge clk);
      #1;
      chk({t, "_no_retrigger"}, 64'({mem_read, mem_write, done}), 64'(0));
      valid_in = 1'b0;
   endtask

   vec_t vt [13];

   initial begin : main
      int nreq;
      bit prev_req, prev_resp;
      mem[16'h1234] = 16'hBEEF;
      mem[16'h2000] = 16'h80FF;
      mem[16'h4000] = 16'h5003;
      mem[16'h6000] = 16'h7011;
      mem[16'h7010] = 16'h1357;
      mem[16'h0040] = 16'h0200;

      //        op       addr     sd       lat scr n  w1 a1       d1       be1    w2 a2       d2       be2    st  ld
      vt[0]  = mk(OP_LDR,  16'h1235, 16'h0000, 1, 0, 1, 0, 16'h1234, 16'h0,   2'b00, 0, 16'h0,   16'h0,   2'b00, 2,  16'hBEEF);
      vt[1]  = mk(OP_LDB,  16'h2001, 16'h0000, 1, 0, 1, 0, 16'h2001, 16'h0,   2'b00, 0, 16'h0,   16'h0,   2'b00, 2,  16'hFF80);
      vt[2]  = mk(OP_LDB,  16'h2000, 16'h0000, 1, 0, 1, 0, 16'h2000, 16'h0,   2'b00, 0, 16'h0,   16'h0,   2'b00, 2,  16'hFFFF);
      vt[3]  = mk(OP_STB,  16'h3001, 16'h1234, 1, 0, 1, 1, 16'h3001, 16'h3434, 2'b10, 0, 16'h0,   16'h0,   2'b00, 2,  16'hFFFF);
      vt[4]  = mk(OP_STI,  16'h4000, 16'hCAFE, 1, 0, 2, 0, 16'h4000, 16'h0,   2'b00, 1, 16'h5002, 16'hCAFE, 2'b11, 3,  16'hFFFF);
      vt[5]  = mk(OP_LDI,  16'h6001, 16'h0000, 5, 0, 2, 0, 16'h6000, 16'h0,   2'b00, 0, 16'h7010, 16'h0,   2'b00, 11, 16'h1357);
      vt[6]  = mk(OP_TRAP, 16'h0041, 16'h0000, 1, 0, 1, 0, 16'h0040, 16'h0,   2'b00, 0, 16'h0,   16'h0,   2'b00, 2,  16'h0200);
      vt[7]  = mk(OP_STR,  16'h0051, 16'hA5A5, 2, 0, 1, 1, 16'h0050, 16'hA5A5, 2'b11, 0, 16'h0,   16'h0,   2'b00, 3,  16'h0200);
      vt[8]  = mk(OP_LDR,  16'h0050, 16'h0000, 3, 1, 1, 0, 16'h0050, 16'h0,   2'b00, 0, 16'h0,   16'h0,   2'b00, 4,  16'hA5A5);
      vt[9]  = mk(OP_STB,  16'h3000, 16'h00C3, 1, 0, 1, 1, 16'h3000, 16'hC3C3, 2'b01, 0, 16'h0,   16'h0,   2'b00, 2,  16'hA5A5);
      vt[10] = mk(OP_LDB,  16'h3001, 16'h0000, 1, 0, 1, 0, 16'h3001, 16'h0,   2'b00, 0, 16'h0,   16'h0,   2'b00, 2,  16'h0034);
      vt[11] = mk(OP_LDR,  16'h5003, 16'h0000, 1, 0, 1, 0, 16'h5002, 16'h0,   2'b00, 0, 16'h0,   16'h0,   2'b00, 2,  16'hCAFE);
      vt[12] = mk(OP_LDB,  16'h1234, 16'h0000, 1, 0, 1, 0, 16'h1234, 16'h0,   2'b00, 0, 16'h0,   16'h0,   2'b00, 2,  16'hFFEF);

      // Reset state.
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("reset_outputs", 64'({mem_read, mem_write, mem_address, mem_wdata,
                               mem_byte_enable, load_data, stall, done}), 64'(0));
      rst = 1'b0;

      for (int i = 0; i < 13; i++) run(vt[i], i);

      chk("sti_mem_written", 64'(rd(16'h5002)), 64'(16'hCAFE));
      chk("stb_mem_merged", 64'(rd(16'h3000)), 64'(16'h34C3));

      // Non-memory op and invalid memory op: no stall, no request.
      @(negedge clk);
      valid_in = 1'b1; opcode = OP_ADD; addr = 16'h1235;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("nonmem_idle", 64'({stall, mem_read, mem_write, done}), 64'(0));
         chk("nonmem_load_kept", 64'(load_data), 64'(16'hFFEF));
         @(negedge clk);
      end
      valid_in = 1'b0; opcode = OP_LDR;
      #1;
      chk("invalid_ldr_no_stall", 64'({stall, mem_read}), 64'(0));
      @(negedge clk);
      #1;
      chk("invalid_ldr_no_req", 64'({stall, mem_read, mem_write}), 64'(0));

      // Reset during the second access of LDI, then a stray response.
      @(negedge clk);
      valid_in = 1'b1; opcode = OP_LDI; addr = 16'h6000; lat = 3;
      nreq = 0; prev_req = 0; prev_resp = 0;
      for (int c = 0; c < 40 && nreq < 2; c++) begin
         #1;
         if ((mem_read || mem_write) && (!prev_req || prev_resp)) nreq++;
         prev_req  = mem_read || mem_write;
         prev_resp = mem_resp;
         if (nreq < 2) @(negedge clk);
      end
      chk("rst_seq_reached_req2", 64'(nreq), 64'(2));
      chk("rst_seq_req2_addr", 64'(mem_address), 64'(16'h7010));
      rst = 1'b1;
      valid_in = 1'b0;
      #1;
      chk("async_reset_outputs", 64'({mem_read, mem_write, mem_address, mem_wdata,
                                     mem_byte_enable, load_data, stall, done}), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      tb_stray = 1'b1;
      @(negedge clk);
      tb_stray = 1'b0;
      #1;
      chk("stray_resp_ignored", 64'({mem_read, mem_write, mem_address,
                                    load_data, stall, done}), 64'(0));
      @(negedge clk);
      #1;
      chk("stays_idle", 64'({mem_read, mem_write, load_data, stall, done}), 64'(0));
      chk("sb_drained", 64'(sb.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage sequencer for the LC-3b pipeline; consumes the decoded opcode and effective address produced by decode/execute.
- Issues one or two data-memory transactions per instruction: LDR/STR/LDB/STB/TRAP take one, LDI/STI take two.
- Handles byte lanes, sign extension and indirection.
- Holds the pipeline via stall until the result is registered for MEM/WB.

Parameters:
- WIDTH, 16, data/address width (LC-3b word).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- valid_in  in  1  MEM-stage instruction valid.
- opcode  in  4  lc3b_opcode of the MEM-stage instruction.
- addr  in  16  effective address from execute.
- store_data  in  16  SR value for STR/STB/STI.
- mem_resp  in  1  data-memory completion strobe.
- mem_rdata  in  16  data-memory read data.
- mem_read  out  1  data-memory read request.
- mem_write  out  1  data-memory write request.
- mem_address  out  16  data-memory address.
- mem_wdata  out  16  data-memory write data.
- mem_byte_enable  out  2  write byte lanes; [1] is the high byte.
- load_data  out  16  registered load/TRAP result for writeback.
- stall  out  1  hold all upstream pipeline registers.
- done  out  1  one-cycle pulse when the result is final.

Behaviour:
- Memory ops are op_ldr, op_str, op_ldb, op_stb, op_ldi, op_sti and op_trap. All other opcodes, or valid_in=0, are non-memory.
- States: IDLE, REQ1, REQ2, DONE. rst forces IDLE asynchronously.
- Reset values:
  - mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, mem_byte_enable=2'b00.
  - load_data=0, stall=0, done=0.
- IDLE:
  - valid memory op → REQ1, capturing opcode, addr and store_data into internal registers.
  - Non-memory → stay in IDLE, stall=0, load_data unchanged.
- REQ1, first access, using captured values:
  - LDR/LDI/TRAP: read at {addr[15:1],0}.
  - LDB: read at addr with bit0 kept.
  - STR: write store_data at {addr[15:1],0}, byte_enable=11.
  - STB: write {store_data[7:0],store_data[7:0]}, byte_enable=10 if addr[0] else 01.
  - STI: read pointer at {addr[15:1],0}.
- Exiting REQ1 on mem_resp:
  - LDI/STI → REQ2, capture pointer={mem_rdata[15:1],0}.
  - Others → DONE.
  - LDR/TRAP: load_data<=mem_rdata.
  - LDB: load_data<=sign-extended mem_rdata[15:8] if addr[0], else [7:0].
- REQ2, second access at the captured pointer:
  - LDI: read; load_data<=mem_rdata on mem_resp.
  - STI: write store_data, byte_enable=11.
  - Goes to DONE on mem_resp.
- DONE: done=1, stall=0; unconditionally → IDLE. The instruction still on valid_in this cycle is the completing one and must not re-trigger.
- Request rules:
  - mem_read/mem_write are asserted only in REQ1/REQ2 and never together.
  - Address, data and byte enables stay stable and the request stays high until mem_resp.
  - Requests drop in the cycle after mem_resp.
- mem_resp in IDLE/DONE is ignored.
- byte_enable is 00 whenever mem_write=0.
- stall = (IDLE & valid memory op) | REQ1 | REQ2. It is combinational.
- Latency with a 1-cycle memory: single-access ops stall 2 cycles, done in cycle 3; LDI/STI stall 3 cycles, done in cycle 4.
- Reset mid-transaction drops the access; a late mem_resp after reset is ignored.
- Inputs changing during REQ1/REQ2 have no effect, because captured copies are used.

Test Plan:
- LDR, addr=0x1235, memory word at 0x1234=0xBEEF, mem_resp one cycle after request:
  - Expect mem_read with mem_address=0x1234.
  - Expect stall high 2 cycles.
  - Expect done in cycle 3 with load_data=0xBEEF.
- LDB, addr=0x2001, mem_rdata=0x80FF: expect load_data=0xFF80. With addr=0x2000, expect load_data=0xFFFF.
- STB, addr=0x3001, store_data=0x1234: expect mem_write, mem_address=0x3001, mem_wdata=0x3434, byte_enable=10.
- STI, addr=0x4000, pointer word=0x5003, store_data=0xCAFE:
  - Expect a read at 0x4000.
  - Then a write at 0x5002 with 0xCAFE, byte_enable=11.
  - Expect stall high 3 cycles and a single done pulse.
- LDI with mem_resp delayed 4 cycles per access: requests stay stable until each response, stall stays high throughout, and load_data equals the second read.
- rst asserted while in REQ2, with a stray mem_resp the next cycle: all outputs return to 0 immediately, the FSM stays in IDLE, and load_data is not updated.
